// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the PE feeder slice.
package pe_pkg;

  localparam int PIX_W = 8;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_BG  = 1'b1;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    LOAD    = 6'b000010,
    START   = 6'b000100,
    WAIT    = 6'b001000,
    DRAIN   = 6'b010000,
    SUM_OUT = 6'b100000
  } state_t;

endpackage

// File: rtl/pe_feeder_if.sv
// Feeder <-> PE bus: packed pixel inputs, start/ack pulses, done flags and results.
interface pe_feeder_if #(
  parameter int NUM_PIXELS = 4
);
  import pe_pkg::*;

  localparam int VW = NUM_PIXELS*PIX_W;

  logic [VW-1:0] red_in, green_in, blue_in;
  logic          Start_Sum, Start_BgRemoval, Ack;
  logic          Qsd, Qbgd;
  logic [VW-1:0] red_out, green_out, blue_out;
  logic [VW-1:0] red_sum, green_sum, blue_sum;

  modport master (
    output red_in, green_in, blue_in, Start_Sum, Start_BgRemoval, Ack,
    input  Qsd, Qbgd, red_out, green_out, blue_out, red_sum, green_sum, blue_sum
  );

  modport slave (
    input  red_in, green_in, blue_in, Start_Sum, Start_BgRemoval, Ack,
    output Qsd, Qbgd, red_out, green_out, blue_out, red_sum, green_sum, blue_sum
  );

endinterface

// File: rtl/pix_pack.sv
// Slot-addressed register write of one 8-bit pixel into an N-slot packed vector.
module pix_pack
  import pe_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N+1)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               wr_en,
  input  logic [SW-1:0]      wr_slot,
  input  logic [PIX_W-1:0]   wr_data,
  output logic [N*PIX_W-1:0] vec
);

  logic [N-1:0][PIX_W-1:0] q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N; k++)
        if (wr_slot == SW'(k)) q[k] <= wr_data;
    end
  end

  assign vec = q;

endmodule

// File: rtl/pe_feeder.sv
// Batches a serial RGB stream into the PE, starts it, waits for done, acks and streams results.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int NUM_PIXELS = 4
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic                        pix_mode,
  input  logic [PIX_W-1:0]            pix_r,
  input  logic [PIX_W-1:0]            pix_g,
  input  logic [PIX_W-1:0]            pix_b,
  pe_feeder_if.master                 pe,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PIX_W-1:0]            out_r,
  output logic [PIX_W-1:0]            out_g,
  output logic [PIX_W-1:0]            out_b,
  output logic                        sum_valid,
  input  logic                        sum_ready,
  output logic [NUM_PIXELS*PIX_W-1:0] sum_r,
  output logic [NUM_PIXELS*PIX_W-1:0] sum_g,
  output logic [NUM_PIXELS*PIX_W-1:0] sum_b
);

  localparam int              CW   = $clog2(NUM_PIXELS+1);
  localparam int              VW   = NUM_PIXELS*PIX_W;
  localparam logic [CW-1:0]   LAST = CW'(NUM_PIXELS-1);

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d, wr_slot;
  logic                 mode, mode_d, wr_en, capture, done;
  logic                 start_sum_q, start_bg_q, ack_q;
  logic [2:0][PIX_W-1:0] pix_c, out_c;
  logic [2:0][VW-1:0]   in_vec, res_pe, sum_pe, res_q, sum_q;

  // channel index 0/1/2 = red/green/blue throughout
  assign pix_c  = {pix_b, pix_g, pix_r};
  assign res_pe = {pe.blue_out, pe.green_out, pe.red_out};
  assign sum_pe = {pe.blue_sum, pe.green_sum, pe.red_sum};
  assign done   = (mode == MODE_SUM) ? pe.Qsd : pe.Qbgd;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    pix_pack #(.N(NUM_PIXELS), .SW(CW)) u_pack (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .wr_en   (wr_en),
      .wr_slot (wr_slot),
      .wr_data (pix_c[c]),
      .vec     (in_vec[c])
    );
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mode_d  = mode;
    wr_en   = 1'b0;
    wr_slot = cnt;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        wr_slot = '0;
        if (pix_valid && pix_ready) begin
          wr_en   = 1'b1;
          mode_d  = pix_mode;
          cnt_d   = CW'(1);
          state_d = (NUM_PIXELS == 1) ? START : LOAD;
        end
      end
      LOAD: begin
        if (pix_valid && pix_ready) begin
          wr_en = 1'b1;
          cnt_d = cnt + CW'(1);
          if (cnt == LAST) state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (done) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = (mode == MODE_SUM) ? SUM_OUT : DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          cnt_d = cnt + CW'(1);
          if (cnt == LAST) state_d = IDLE;
        end
      end
      SUM_OUT: if (sum_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses and pix_ready come from next-state so they line up with the state they belong to
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mode        <= MODE_SUM;
      pix_ready   <= 1'b0;
      start_sum_q <= 1'b0;
      start_bg_q  <= 1'b0;
      ack_q       <= 1'b0;
      res_q       <= '0;
      sum_q       <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      mode        <= mode_d;
      pix_ready   <= (state_d == IDLE) || (state_d == LOAD);
      start_sum_q <= (state_d == START) && (mode_d == MODE_SUM);
      start_bg_q  <= (state_d == START) && (mode_d == MODE_BG);
      ack_q       <= capture;
      if (capture) begin
        res_q <= res_pe;
        sum_q <= sum_pe;
      end
    end
  end

  always_comb begin
    out_c = '0;
    for (int k = 0; k < NUM_PIXELS; k++)
      if (cnt == CW'(k))
        for (int c = 0; c < 3; c++) out_c[c] = res_q[c][k*PIX_W +: PIX_W];
  end

  assign pe.red_in          = in_vec[0];
  assign pe.green_in        = in_vec[1];
  assign pe.blue_in         = in_vec[2];
  assign pe.Start_Sum       = start_sum_q;
  assign pe.Start_BgRemoval = start_bg_q;
  assign pe.Ack             = ack_q;

  assign out_valid = (state == DRAIN);
  assign out_r     = out_c[0];
  assign out_g     = out_c[1];
  assign out_b     = out_c[2];
  assign sum_valid = (state == SUM_OUT);
  assign sum_r     = sum_q[0];
  assign sum_g     = sum_q[1];
  assign sum_b     = sum_q[2];

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: a 4-pixel instance and a 1-pixel instance with hand-driven PE responses.
module tb_pe_feeder;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  // 4-pixel instance
  logic        pix_valid4, pix_ready4, pix_mode4, out_valid4, out_ready4, sum_valid4, sum_ready4;
  logic [7:0]  pix_r4, pix_g4, pix_b4, out_r4, out_g4, out_b4;
  logic [31:0] sum_r4, sum_g4, sum_b4;
  pe_feeder_if #(.NUM_PIXELS(4)) pe4 ();

  pe_feeder #(.NUM_PIXELS(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid4), .pix_ready(pix_ready4), .pix_mode(pix_mode4),
    .pix_r(pix_r4), .pix_g(pix_g4), .pix_b(pix_b4),
    .pe(pe4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_r(out_r4), .out_g(out_g4), .out_b(out_b4),
    .sum_valid(sum_valid4), .sum_ready(sum_ready4),
    .sum_r(sum_r4), .sum_g(sum_g4), .sum_b(sum_b4)
  );

  // 1-pixel instance
  logic        pix_valid1, pix_ready1, pix_mode1, out_valid1, out_ready1, sum_valid1, sum_ready1;
  logic [7:0]  pix_r1, pix_g1, pix_b1, out_r1, out_g1, out_b1;
  logic [7:0]  sum_r1, sum_g1, sum_b1;
  pe_feeder_if #(.NUM_PIXELS(1)) pe1 ();

  pe_feeder #(.NUM_PIXELS(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid1), .pix_ready(pix_ready1), .pix_mode(pix_mode1),
    .pix_r(pix_r1), .pix_g(pix_g1), .pix_b(pix_b1),
    .pe(pe1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_r(out_r1), .out_g(out_g1), .out_b(out_b1),
    .sum_valid(sum_valid1), .sum_ready(sum_ready1),
    .sum_r(sum_r1), .sum_g(sum_g1), .sum_b(sum_b1)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_ss4 = 0, n_sb4 = 0, n_ack4 = 0;

  always @(negedge Clk) begin
    if (pe4.Start_Sum)       n_ss4++;
    if (pe4.Start_BgRemoval) n_sb4++;
    if (pe4.Ack)             n_ack4++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send4(input logic [3:0] modes, input logic [31:0] r, g, b);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("ready_load", pix_ready4, 1'b1);
      pix_valid4 = 1'b1;
      pix_mode4  = modes[k];
      pix_r4     = r[8*k +: 8];
      pix_g4     = g[8*k +: 8];
      pix_b4     = b[8*k +: 8];
    end
    @(negedge Clk);
    pix_valid4 = 1'b0;
    chk("ready_start", pix_ready4, 1'b0);
    chk("red_in", pe4.red_in, r);
    chk("green_in", pe4.green_in, g);
    chk("blue_in", pe4.blue_in, b);
  endtask

  task automatic chk_all_zero4();
    chk("rst_pix_ready", pix_ready4, 1'b0);
    chk("rst_start_sum", pe4.Start_Sum, 1'b0);
    chk("rst_start_bg", pe4.Start_BgRemoval, 1'b0);
    chk("rst_ack", pe4.Ack, 1'b0);
    chk("rst_out_valid", out_valid4, 1'b0);
    chk("rst_sum_valid", sum_valid4, 1'b0);
    chk("rst_red_in", {pe4.blue_in, pe4.green_in, pe4.red_in}, 96'h0);
    chk("rst_out", {out_r4, out_g4, out_b4}, 24'h0);
    chk("rst_sum", {sum_r4, sum_g4, sum_b4}, 96'h0);
  endtask

  initial begin
    int base_ss, base_sb, base_ack, e;
    logic [5:0]  pat;
    logic [31:0] er, eg, eb;

    {pix_valid4, pix_mode4, out_ready4, sum_ready4, pix_r4, pix_g4, pix_b4} = '0;
    {pix_valid1, pix_mode1, out_ready1, sum_ready1, pix_r1, pix_g1, pix_b1} = '0;
    {pe4.Qsd, pe4.Qbgd, pe4.red_out, pe4.green_out, pe4.blue_out} = '0;
    {pe4.red_sum, pe4.green_sum, pe4.blue_sum} = '0;
    {pe1.Qsd, pe1.Qbgd, pe1.red_out, pe1.green_out, pe1.blue_out} = '0;
    {pe1.red_sum, pe1.green_sum, pe1.blue_sum} = '0;

    // power-on reset
    repeat (2) @(negedge Clk);
    chk_all_zero4();
    chk("rst_pix_ready1", pix_ready1, 1'b0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("ready_after_rst", pix_ready4, 1'b1);
    chk("ready_after_rst1", pix_ready1, 1'b1);

    // two pixels into LOAD, then reset
    pix_valid4 = 1'b1; pix_r4 = 8'h11; pix_g4 = 8'h21; pix_b4 = 8'h31; pix_mode4 = 1'b1;
    @(negedge Clk);
    pix_r4 = 8'h12; pix_g4 = 8'h22; pix_b4 = 8'h32;
    @(negedge Clk);
    pix_valid4 = 1'b0;
    chk("partial_red_in", pe4.red_in, 32'h0000_1211);
    Reset_n = 1'b0;
    #1;
    chk_all_zero4();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("ready_after_rst2", pix_ready4, 1'b1);

    // sum batch
    base_ss = n_ss4; base_sb = n_sb4; base_ack = n_ack4;
    send4(4'b0000, 32'h281E140A, 32'h04030201, 32'hD0C0B0A0);
    chk("sum_start_sum", pe4.Start_Sum, 1'b1);
    chk("sum_start_bg", pe4.Start_BgRemoval, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("sum_wait_start", pe4.Start_Sum, 1'b0);
      chk("sum_wait_ack", pe4.Ack, 1'b0);
      chk("sum_wait_valid", sum_valid4, 1'b0);
    end
    @(negedge Clk);
    pe4.Qsd = 1'b1;
    pe4.red_sum = 32'h64646464; pe4.green_sum = 32'h0A0A0A0A; pe4.blue_sum = 32'h40404040;
    @(negedge Clk);
    chk("sum_ack", pe4.Ack, 1'b1);
    chk("sum_valid", sum_valid4, 1'b1);
    chk("sum_r", sum_r4, 32'h64646464);
    chk("sum_g", sum_g4, 32'h0A0A0A0A);
    chk("sum_b", sum_b4, 32'h40404040);
    pe4.Qsd = 1'b0;
    pe4.red_sum = '1; pe4.green_sum = '1; pe4.blue_sum = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("sum_hold_ack", pe4.Ack, 1'b0);
      chk("sum_hold_valid", sum_valid4, 1'b1);
      chk("sum_hold_r", sum_r4, 32'h64646464);
      chk("sum_hold_b", sum_b4, 32'h40404040);
    end
    sum_ready4 = 1'b1;
    @(negedge Clk);
    sum_ready4 = 1'b0;
    chk("sum_done_valid", sum_valid4, 1'b0);
    chk("sum_done_ready", pix_ready4, 1'b1);
    chk("sum_n_start_sum", n_ss4 - base_ss, 1);
    chk("sum_n_start_bg", n_sb4 - base_sb, 0);
    chk("sum_n_ack", n_ack4 - base_ack, 1);

    // bg batch: mode from pixel 0 only, spurious done flags, stalled drain
    base_ss = n_ss4; base_sb = n_sb4; base_ack = n_ack4;
    pe4.Qbgd = 1'b1;
    send4(4'b0001, 32'h44332211, 32'h88776655, 32'hCCBBAA99);
    pe4.Qbgd = 1'b0;
    chk("bg_start_bg", pe4.Start_BgRemoval, 1'b1);
    chk("bg_start_sum", pe4.Start_Sum, 1'b0);
    chk("bg_load_ack", pe4.Ack, 1'b0);
    pe4.Qsd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("bg_spur_ack", pe4.Ack, 1'b0);
      chk("bg_spur_valid", out_valid4, 1'b0);
    end
    pe4.Qsd = 1'b0;
    pe4.Qbgd = 1'b1;
    er = 32'hDDCCBBAA; eg = 32'h1D1C1B1A; eb = 32'h2D2C2B2A;
    pe4.red_out = er; pe4.green_out = eg; pe4.blue_out = eb;
    @(negedge Clk);
    pe4.Qbgd = 1'b0;
    pe4.red_out = '1; pe4.green_out = '1; pe4.blue_out = '1;
    chk("bg_ack", pe4.Ack, 1'b1);
    pat = 6'b101101;
    e = 0;
    for (int j = 0; j < 6; j++) begin
      chk("drain_valid", out_valid4, 1'b1);
      chk("drain_r", out_r4, er[8*e +: 8]);
      chk("drain_g", out_g4, eg[8*e +: 8]);
      chk("drain_b", out_b4, eb[8*e +: 8]);
      chk("drain_pix_ready", pix_ready4, 1'b0);
      if (j == 1) chk("drain_ack_once", pe4.Ack, 1'b0);
      out_ready4 = pat[j];
      if (pat[j]) e++;
      @(negedge Clk);
    end
    out_ready4 = 1'b0;
    chk("drain_end_valid", out_valid4, 1'b0);
    chk("drain_end_ready", pix_ready4, 1'b1);
    chk("bg_n_start_bg", n_sb4 - base_sb, 1);
    chk("bg_n_start_sum", n_ss4 - base_ss, 0);
    chk("bg_n_ack", n_ack4 - base_ack, 1);

    // single-pixel batch
    pix_valid1 = 1'b1; pix_mode1 = 1'b0; pix_r1 = 8'h5A; pix_g1 = 8'h6B; pix_b1 = 8'h7C;
    @(negedge Clk);
    pix_valid1 = 1'b0;
    chk("n1_start_sum", pe1.Start_Sum, 1'b1);
    chk("n1_ready", pix_ready1, 1'b0);
    chk("n1_in", {pe1.red_in, pe1.green_in, pe1.blue_in}, 24'h5A6B7C);
    pe1.Qsd = 1'b1; pe1.red_sum = 8'h77; pe1.green_sum = 8'h66; pe1.blue_sum = 8'h55;
    @(negedge Clk);
    chk("n1_start_once", pe1.Start_Sum, 1'b0);
    chk("n1_ack_wait", pe1.Ack, 1'b0);
    @(negedge Clk);
    pe1.Qsd = 1'b0;
    chk("n1_ack", pe1.Ack, 1'b1);
    chk("n1_sum_valid", sum_valid1, 1'b1);
    chk("n1_sum", {sum_r1, sum_g1, sum_b1}, 24'h776655);
    sum_ready1 = 1'b1;
    @(negedge Clk);
    sum_ready1 = 1'b0;
    chk("n1_done_valid", sum_valid1, 1'b0);
    chk("n1_done_ready", pix_ready1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
